arb_requester: RTL and testbench

Client-side companion to the two-port request/grant arbiter: one instance sits on each arbiter port. It accepts burst jobs from local logic over a valid/ready handshake, queues them, raises `req`, waits for the registered `gnt`, issues one beat strobe per granted cycle for the burst length, then releases the port. An optional watchdog abandons requests that are never granted.

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_req_fifo.sv | 64 ++++++
 rtl/arb_requester.sv | 136 +++++++++++++
 tb/tb_arb_requester.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and default sizing for the arbiter requester client.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    RELEASE
  } arb_req_state_t;

  localparam int unsigned ARB_DEPTH = 4;
  localparam int unsigned ARB_LEN_W = 4;

endpackage

// File: rtl/arb_req_fifo.sv
// Job queue: DEPTH x WIDTH synchronous FIFO with occupancy count.
// The head entry is presented combinationally on rdata; push is accepted
// when not full, or when full together with a pop.
module arb_req_fifo
  import arb_pkg::*;
#(
  parameter int unsigned DEPTH = ARB_DEPTH,
  parameter int unsigned WIDTH = ARB_LEN_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arb_requester.sv
// Client side of the two-port request/grant arbiter: queues burst jobs,
// requests the port, strobes one beat per granted cycle, then releases.
// Optional watchdog enabled by defining ARB_REQ_TIMEOUT_EN.
module arb_requester
  import arb_pkg::*;
#(
  parameter int unsigned DEPTH   = ARB_DEPTH,
  parameter int unsigned LEN_W   = ARB_LEN_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [LEN_W-1:0]       cmd_len,
  output logic                   req,
  input  logic                   gnt,
  output logic                   beat,
  output logic                   beat_last,
  output logic                   done,
  output logic                   abort,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] q_count
);

  arb_req_state_t   state;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] head_len;
  logic             q_full;
  logic             q_empty;
  logic             q_push;
  logic             q_pop;
  logic             wd_expired;

  assign cmd_ready = !q_full;
  assign q_push    = cmd_valid && cmd_ready;
  assign q_pop     = (state == REQ) && (gnt || wd_expired);
  assign beat      = (state == XFER) && gnt;
  assign beat_last = beat && (beat_cnt == '0);
  assign busy      = (state != IDLE) || !q_empty;

  arb_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (LEN_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (q_push),
    .wdata (cmd_len),
    .pop   (q_pop),
    .rdata (head_len),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt;

  // Counts cycles spent ungranted in REQ; cleared whenever REQ is left.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if ((state == REQ) && !gnt && !wd_expired) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign wd_expired = (state == REQ) && (wd_cnt == WD_LAST);
`else
  assign wd_expired = 1'b0;
`endif

  // Request FSM with registered req/done/abort and the beat down-counter.
  // Grant loss and watchdog expiry both route through RELEASE so req is
  // never re-raised until the arbiter has dropped gnt.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req      <= 1'b0;
      done     <= 1'b0;
      abort    <= 1'b0;
      beat_cnt <= '0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (!q_empty) begin
            state <= REQ;
            req   <= 1'b1;
          end
        end
        REQ: begin
          if (gnt) begin
            state    <= XFER;
            beat_cnt <= head_len;
          end else if (wd_expired) begin
            state <= RELEASE;
            req   <= 1'b0;
            abort <= 1'b1;
          end
        end
        XFER: begin
          if (!gnt) begin
            state <= RELEASE;
            req   <= 1'b0;
            abort <= 1'b1;
          end else if (beat_cnt == '0) begin
            state <= RELEASE;
            req   <= 1'b0;
            done  <= 1'b1;
          end else begin
            beat_cnt <= beat_cnt - 1'b1;
          end
        end
        RELEASE: begin
          if (!gnt) begin
            if (!q_empty) begin
              state <= REQ;
              req   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester with a one-cycle registered arbiter model.
module tb_arb_requester;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_len;
  logic       req;
  logic       gnt;
  logic       beat;
  logic       beat_last;
  logic       done;
  logic       abort;
  logic       busy;
  logic [2:0] q_count;

  logic gnt_en;

  int n_checks = 0;
  int n_errors = 0;
  int c_beats, c_lasts, c_dones, c_aborts;

  arb_requester #(
    .DEPTH   (4),
    .LEN_W   (4),
    .TIMEOUT (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .req       (req),
    .gnt       (gnt),
    .beat      (beat),
    .beat_last (beat_last),
    .done      (done),
    .abort     (abort),
    .busy      (busy),
    .q_count   (q_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Arbiter model: grant follows req one cycle later while enabled.
  always @(posedge clock or posedge reset) begin
    if (reset) gnt <= 1'b0;
    else       gnt <= req && gnt_en;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    c_beats = 0; c_lasts = 0; c_dones = 0; c_aborts = 0;
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (beat) c_beats++;
      if (beat && beat_last) c_lasts++;
      if (done) c_dones++;
      if (abort) c_aborts++;
    end
  endtask

  int lens [4];
  int blen, nbursts, gap, mn_gap, mx_gap, bad;
  bit seen_req;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; gnt_en = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_req", req, 0);
    check("rst_beat", beat, 0);
    check("rst_beat_last", beat_last, 0);
    check("rst_done", done, 0);
    check("rst_abort", abort, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_q_count", q_count, 0);

    reset = 1'b0; gnt_en = 1'b1;
    tick();

    // Test 1: single 4-beat job, grant one cycle after req
    cmd_valid = 1'b1; cmd_len = 4'd3;            // cycle 0
    tick(); cmd_valid = 1'b0;                    // cycle 1
    check("t1_q_count_c1", q_count, 1);
    check("t1_req_c1", req, 0);
    tick();                                      // cycle 2
    check("t1_req_c2", req, 1);
    tick();                                      // cycle 3: gnt arrives
    check("t1_no_beat_c3", beat, 0);
    for (int i = 0; i < 4; i++) begin            // cycles 4..7
      tick();
      check("t1_beat", beat, 1);
      check("t1_beat_last", beat_last, (i == 3));
    end
    tick();                                      // cycle 8
    check("t1_done", done, 1);
    check("t1_req_low", req, 0);
    tick();                                      // cycle 9
    check("t1_done_pulse", done, 0);
    check("t1_busy_release", busy, 1);
    tick();                                      // cycle 10
    check("t1_idle", busy, 0);

    // Test 2: four jobs 0..3 with the arbiter held off until the queue fills
    gnt_en = 1'b0;
    cmd_valid = 1'b1; cmd_len = 4'd0;
    tick(); cmd_len = 4'd1;
    tick(); cmd_len = 4'd2;
    tick(); cmd_len = 4'd3;
    check("t2_q_count_3", q_count, 3);
    check("t2_ready_3", cmd_ready, 1);
    tick(); cmd_len = 4'd7;
    check("t2_q_count_full", q_count, 4);
    check("t2_ready_full", cmd_ready, 0);
    tick(); cmd_valid = 1'b0;
    check("t2_no_push_full", q_count, 4);
    gnt_en = 1'b1;
    blen = 0; nbursts = 0; gap = 0; mn_gap = 1000; mx_gap = 0; seen_req = 1'b0;
    clear_counts();
    for (int i = 0; i < 60; i++) begin
      tick();
      if (beat) blen++;
      if (beat && beat_last) begin
        if (nbursts < 4) lens[nbursts] = blen;
        nbursts++;
        blen = 0;
      end
      if (done) c_dones++;
      if (abort) c_aborts++;
      if (req) begin
        if (seen_req && gap > 0) begin
          if (gap < mn_gap) mn_gap = gap;
          if (gap > mx_gap) mx_gap = gap;
        end
        gap = 0;
        seen_req = 1'b1;
      end else if (seen_req) begin
        gap++;
      end
    end
    check("t2_nbursts", nbursts, 4);
    for (int i = 0; i < 4; i++) check("t2_burst_len", lens[i], i + 1);
    check("t2_dones", c_dones, 4);
    check("t2_aborts", c_aborts, 0);
    check("t2_min_gap", mn_gap, 2);
    check("t2_max_gap", mx_gap, 2);
    check("t2_q_empty", q_count, 0);
    check("t2_idle", busy, 0);

    // Test 3: grant withheld for 10 cycles
    gnt_en = 1'b0;
    cmd_valid = 1'b1; cmd_len = 4'd2;
    tick(); cmd_valid = 1'b0;
    tick();
    check("t3_req", req, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!req || beat) bad++;
    end
    check("t3_wait_steady", bad, 0);
    gnt_en = 1'b1;
    clear_counts();
    observe(12);
    check("t3_beats", c_beats, 3);
    check("t3_lasts", c_lasts, 1);
    check("t3_dones", c_dones, 1);
    check("t3_aborts", c_aborts, 0);
    check("t3_idle", busy, 0);

    // Test 4: grant lost after 2 of 8 beats, next job proceeds
    cmd_valid = 1'b1; cmd_len = 4'd7;            // cycle 0
    tick(); cmd_len = 4'd1;                      // cycle 1
    tick(); cmd_valid = 1'b0;                    // cycle 2
    check("t4_req", req, 1);
    check("t4_q_count", q_count, 2);
    clear_counts();
    observe(3);                                  // cycles 3..5
    check("t4_beats_before_drop", c_beats, 2);
    gnt_en = 1'b0;
    observe(2);                                  // cycles 6..7
    check("t4_abort", abort, 1);
    check("t4_req_low", req, 0);
    check("t4_abort_count", c_aborts, 1);
    check("t4_no_done", c_dones, 0);
    check("t4_beats_total", c_beats, 2);
    gnt_en = 1'b1;
    clear_counts();
    observe(10);                                 // cycles 8..17
    check("t4_next_beats", c_beats, 2);
    check("t4_next_lasts", c_lasts, 1);
    check("t4_next_done", c_dones, 1);
    check("t4_next_abort", c_aborts, 0);
    check("t4_q_empty", q_count, 0);
    check("t4_idle", busy, 0);

    // Test 5: grant never given
    gnt_en = 1'b0;
    cmd_valid = 1'b1; cmd_len = 4'd0;
    tick(); cmd_valid = 1'b0;
    tick();                                      // cycle 2: REQ entered
    check("t5_req", req, 1);
    clear_counts();
`ifdef ARB_REQ_TIMEOUT_EN
    observe(15);                                 // cycles 3..17
    check("t5_no_early_abort", c_aborts, 0);
    check("t5_req_held", req, 1);
    tick();                                      // cycle 18
    check("t5_abort", abort, 1);
    check("t5_req_low", req, 0);
    check("t5_head_dropped", q_count, 0);
    tick();
    check("t5_idle", busy, 0);
`else
    observe(100);
    check("t5_req_still_high", req, 1);
    check("t5_no_abort", c_aborts, 0);
    check("t5_no_beats", c_beats, 0);
    check("t5_job_kept", q_count, 1);
`endif

    // Test 6: reset during beat 3 of 8 with 2 jobs queued
    reset = 1'b1;
    tick();
    reset = 1'b0; gnt_en = 1'b1;
    cmd_valid = 1'b1; cmd_len = 4'd7;            // cycle 0
    tick(); cmd_len = 4'd0;                      // cycle 1
    tick(); cmd_len = 4'd1;                      // cycle 2
    tick(); cmd_valid = 1'b0;                    // cycle 3
    tick(); tick(); tick();                      // cycle 6: third beat
    check("t6_beat3", beat, 1);
    check("t6_queued", q_count, 2);
    reset = 1'b1;
    #1;
    check("t6_req", req, 0);
    check("t6_beat", beat, 0);
    check("t6_beat_last", beat_last, 0);
    check("t6_done", done, 0);
    check("t6_abort", abort, 0);
    check("t6_busy", busy, 0);
    check("t6_q_count", q_count, 0);
    check("t6_cmd_ready", cmd_ready, 1);
    tick();
    reset = 1'b0;
    clear_counts();
    observe(6);
    check("t6_quiet_beats", c_beats, 0);
    check("t6_quiet_done", c_dones + c_aborts, 0);
    check("t6_quiet_req", req, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
